// File: rtl/mem_pkg.sv
// Shared constants and state encoding for the wait-state memory responder.
package mem_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_resp_ws_if.sv
// Valid/ready memory bus between an initiator (master) and the responder (slave).
interface mem_resp_ws_if
    import mem_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

    logic                  valid_i;
    logic                  wr_rd;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [WIDTH-1:0]      wdata_i;
    logic [WIDTH-1:0]      rdata_o;
    logic                  ready_o;
    logic                  err_o;

    modport master (
        output valid_i, wr_rd, addr_i, wdata_i,
        input  rdata_o, ready_o, err_o
    );

    modport slave (
        input  valid_i, wr_rd, addr_i, wdata_i,
        output rdata_o, ready_o, err_o
    );

endinterface

// File: rtl/mem_array.sv
// Single-port synchronous storage; read data is registered and held until the next read.
module mem_array
    import mem_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rdata_r;

    // Storage write and registered read; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        if (re) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/mem_resp_ws.sv
// Memory-side bus responder: accepts a request, waits WAIT_STATES cycles, then
// performs the access and pulses ready_o (with err_o for addresses >= DEPTH).
module mem_resp_ws
    import mem_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mem_resp_ws_if.slave      bus
);

    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [CNT_W-1:0]    WS_L    = CNT_W'(WAIT_STATES);

    state_e                state_r, state_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic                  wr_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [WIDTH-1:0]      wdata_r;
    logic                  ready_r, err_r, rd_ok_r;

    logic                  cap_s, acc_s;
    logic                  acc_wr_s;
    logic [ADDR_WIDTH-1:0] acc_addr_s;
    logic [WIDTH-1:0]      acc_wdata_s;
    logic                  oor_s, we_s, re_s;
    logic [WIDTH-1:0]      arr_rdata_s;

    // State and wait counter registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic; acc_s marks the edge on which the array is accessed.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        cap_s   = 1'b0;
        acc_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.valid_i) begin
                    cap_s = 1'b1;
                    cnt_s = WS_L;
                    if (WAIT_STATES == 0) begin
                        acc_s   = 1'b1;
                        state_s = RESP;
                    end else begin
                        state_s = WAIT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd1) begin
                    acc_s   = 1'b1;
                    cnt_s   = 4'd0;
                    state_s = RESP;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Zero-wait accesses happen on the accept edge, so they use the live bus values.
    always_comb begin
        if (cap_s) begin
            acc_wr_s    = bus.wr_rd;
            acc_addr_s  = bus.addr_i;
            acc_wdata_s = bus.wdata_i;
        end else begin
            acc_wr_s    = wr_r;
            acc_addr_s  = addr_r;
            acc_wdata_s = wdata_r;
        end
    end

    assign oor_s = ({1'b0, acc_addr_s} >= DEPTH_L);
    assign we_s  = acc_s &  acc_wr_s & ~oor_s;
    assign re_s  = acc_s & ~acc_wr_s & ~oor_s;

    // Request capture on accept.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
        end else if (cap_s) begin
            wr_r    <= bus.wr_rd;
            addr_r  <= bus.addr_i;
            wdata_r <= bus.wdata_i;
        end
    end

    // Response pulses and read-data qualifier (an out-of-range read forces zero).
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ready_r <= 1'b0;
            err_r   <= 1'b0;
            rd_ok_r <= 1'b0;
        end else begin
            ready_r <= acc_s;
            err_r   <= acc_s & oor_s;
            if (acc_s & ~acc_wr_s) begin
                rd_ok_r <= ~oor_s;
            end
        end
    end

    mem_array #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk   (clk_i),
        .we    (we_s),
        .re    (re_s),
        .addr  (acc_addr_s),
        .wdata (acc_wdata_s),
        .rdata (arr_rdata_s)
    );

    assign bus.ready_o = ready_r;
    assign bus.err_o   = err_r;
    assign bus.rdata_o = rd_ok_r ? arr_rdata_s : '0;

endmodule

// File: tb/tb_mem_resp_ws.sv
// Directed bench for mem_resp_ws: three instances cover WAIT_STATES 2/0/3 and DEPTH 200.
module tb_mem_resp_ws;

    logic clk = 1'b0;
    logic rst_i = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_resp_ws_if #(.WIDTH(32), .ADDR_WIDTH(8)) ia ();
    mem_resp_ws_if #(.WIDTH(32), .ADDR_WIDTH(8)) ib ();
    mem_resp_ws_if #(.WIDTH(32), .ADDR_WIDTH(8)) ic ();

    mem_resp_ws #(.WIDTH(32), .ADDR_WIDTH(8), .DEPTH(200), .WAIT_STATES(2)) dut_a (
        .clk_i(clk), .rst_i(rst_i), .bus(ia));
    mem_resp_ws #(.WIDTH(32), .ADDR_WIDTH(8), .DEPTH(256), .WAIT_STATES(0)) dut_b (
        .clk_i(clk), .rst_i(rst_i), .bus(ib));
    mem_resp_ws #(.WIDTH(32), .ADDR_WIDTH(8), .DEPTH(256), .WAIT_STATES(3)) dut_c (
        .clk_i(clk), .rst_i(rst_i), .bus(ic));

    logic        rdy  [3];
    logic        er   [3];
    logic [31:0] rdat [3];
    assign rdy[0] = ia.ready_o;  assign er[0] = ia.err_o;  assign rdat[0] = ia.rdata_o;
    assign rdy[1] = ib.ready_o;  assign er[1] = ib.err_o;  assign rdat[1] = ib.rdata_o;
    assign rdy[2] = ic.ready_o;  assign er[2] = ic.err_o;  assign rdat[2] = ic.rdata_o;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic w,
                         input logic [7:0] a, input logic [31:0] wd);
        case (d)
            0: begin ia.valid_i = v; ia.wr_rd = w; ia.addr_i = a; ia.wdata_i = wd; end
            1: begin ib.valid_i = v; ib.wr_rd = w; ib.addr_i = a; ib.wdata_i = wd; end
            default: begin ic.valid_i = v; ic.wr_rd = w; ic.addr_i = a; ic.wdata_i = wd; end
        endcase
    endtask

    // Counts falling edges until ready_o is seen (bounded), then checks the count.
    task automatic wait_rdy(input int d, input int exp_lat, input string tag);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rdy[d] && lat < 20);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic txn(input int d, input logic w, input logic [7:0] a, input logic [31:0] wd,
                       input int exp_lat, input logic exp_err, input logic chk_rd,
                       input logic [31:0] exp_rd, input string tag);
        drive(d, 1'b1, w, a, wd);
        wait_rdy(d, exp_lat, tag);
        chk({tag, "_err"}, {31'd0, er[d]}, {31'd0, exp_err});
        if (chk_rd) begin
            chk({tag, "_rdata"}, rdat[d], exp_rd);
        end
    endtask

    initial begin
        int pulses;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 8'h00, 32'h0);
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_ready%0d", d), {31'd0, rdy[d]}, 32'd0);
            chk($sformatf("rst_err%0d", d),   {31'd0, er[d]},  32'd0);
            chk($sformatf("rst_rdata%0d", d), rdat[d],         32'd0);
        end
        rst_i = 1'b1;
        @(negedge clk);

        // WAIT_STATES=2, DEPTH=200; valid stays high through RESP between requests.
        txn(0, 1'b1, 8'h10, 32'hDEADBEEF, 3, 1'b0, 1'b0, 32'h0,        "a_wr10");
        txn(0, 1'b0, 8'h10, 32'h0,        4, 1'b0, 1'b1, 32'hDEADBEEF, "a_rd10");
        txn(0, 1'b1, 8'h20, 32'h12345678, 4, 1'b0, 1'b1, 32'hDEADBEEF, "a_wr20_hold");
        txn(0, 1'b1, 8'hC7, 32'h00000077, 4, 1'b0, 1'b0, 32'h0,        "a_wrC7");
        txn(0, 1'b1, 8'hC8, 32'h00000055, 4, 1'b1, 1'b0, 32'h0,        "a_wrC8");
        txn(0, 1'b0, 8'hC8, 32'h0,        4, 1'b1, 1'b1, 32'h0,        "a_rdC8");
        txn(0, 1'b0, 8'hC7, 32'h0,        4, 1'b0, 1'b1, 32'h00000077, "a_rdC7");
        drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        chk("a_ready_drop", {31'd0, rdy[0]}, 32'd0);
        chk("a_rdata_hold", rdat[0], 32'h00000077);

        // WAIT_STATES=0: back-to-back writes then reads, one ready_o every 2 cycles.
        for (int i = 0; i < 4; i++) begin
            txn(1, 1'b1, 8'(i), 32'(8'h11 * (i + 1)), (i == 0) ? 1 : 2, 1'b0, 1'b0, 32'h0,
                $sformatf("b_wr%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            txn(1, 1'b0, 8'(i), 32'h0, 2, 1'b0, 1'b1, 32'(8'h11 * (i + 1)),
                $sformatf("b_rd%0d", i));
        end
        drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        chk("b_ready_drop", {31'd0, rdy[1]}, 32'd0);

        // WAIT_STATES=3: inputs altered during WAIT, valid held through RESP.
        drive(2, 1'b1, 1'b1, 8'h07, 32'h00000070);
        @(negedge clk);
        drive(2, 1'b1, 1'b1, 8'h08, 32'h00000080);
        wait_rdy(2, 3, "c_first");
        wait_rdy(2, 5, "c_second");
        txn(2, 1'b0, 8'h07, 32'h0,        5, 1'b0, 1'b1, 32'h00000070, "c_rd07");
        txn(2, 1'b0, 8'h08, 32'h0,        5, 1'b0, 1'b1, 32'h00000080, "c_rd08");
        txn(2, 1'b1, 8'h06, 32'h00000066, 5, 1'b0, 1'b0, 32'h0,        "c_wr06");
        txn(2, 1'b0, 8'h06, 32'h0,        5, 1'b0, 1'b1, 32'h00000066, "c_rd06");
        drive(2, 1'b0, 1'b0, 8'h00, 32'h0);
        repeat (2) @(negedge clk);

        // Reset one cycle after accepting a write: no response, outputs cleared at once.
        drive(2, 1'b1, 1'b1, 8'h05, 32'h000000AA);
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        drive(2, 1'b0, 1'b0, 8'h00, 32'h0);
        #1;
        chk("c_rst_ready", {31'd0, rdy[2]}, 32'd0);
        chk("c_rst_err",   {31'd0, er[2]},  32'd0);
        chk("c_rst_rdata", rdat[2],         32'd0);
        chk("a_rst_rdata", rdat[0],         32'd0);
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rdy[2]) pulses++;
        end
        chk("c_no_resp_after_rst", 32'(pulses), 32'd0);
        txn(2, 1'b0, 8'h05, 32'h0, 4, 1'b0, 1'b0, 32'h0, "c_rd05");
        n_cmp++;
        assert (rdat[2] !== 32'h000000AA) else begin
            n_err++;
            $error("FAIL c_rd05_aborted: observed %h expected anything but 000000aa", rdat[2]);
        end
        drive(2, 1'b0, 1'b0, 8'h00, 32'h0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
